// File: rtl/mem_arb_pkg.sv
// Shared definitions for the mem_arb SSRAM arbiter: bus widths, FSM state
// encoding and requester identifiers.
package mem_arb_pkg;

    localparam int ADDR_W       = 20;
    localparam int DATA_W       = 36;
    localparam int SSRAM_ADDR_W = 23;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_WR_A = 3'd1;
    localparam state_t ST_WR_D = 3'd2;
    localparam state_t ST_RD_A = 3'd3;
    localparam state_t ST_RD_W = 3'd4;
    localparam state_t ST_RD_D = 3'd5;

    typedef logic req_id_t;

    localparam req_id_t REQ_CPU = 1'b0;
    localparam req_id_t REQ_CON = 1'b1;

    // States in which the granted requester sees its completion pulse.
    function automatic logic is_ack_state(input state_t s);
        return (s == ST_WR_D) || (s == ST_RD_D);
    endfunction

endpackage

// File: rtl/mem_arb.sv
// Two-port (CPU / console) arbiter and sequencer in front of a synchronous SSRAM.
// Define MEM_ARB_FAIR_EN to bound consecutive CPU grants while the console waits.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int FAIR_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpuREQ,
    input  logic                    cpuWR,
    input  logic [ADDR_W-1:0]       cpuADDR,
    input  logic [DATA_W-1:0]       cpuDATAI,
    output logic                    cpuACK,
    output logic [DATA_W-1:0]       cpuDATAO,
    input  logic                    conREQ,
    input  logic                    conWR,
    input  logic [ADDR_W-1:0]       conADDR,
    input  logic [DATA_W-1:0]       conDATAI,
    output logic                    conACK,
    output logic [DATA_W-1:0]       conDATAO,
    output logic [SSRAM_ADDR_W-1:0] ssramADDR,
    output logic                    ssramWE_N,
    output logic                    ssramOE_N,
    output logic [DATA_W-1:0]       ssramDOUT,
    output logic                    ssramDOE,
    input  logic [DATA_W-1:0]       ssramDIN
);

    if (FAIR_LIMIT < 1) begin : g_bad_fair_limit
        $error("mem_arb: FAIR_LIMIT must be at least 1");
    end

    state_t            state_q, state_d;
    req_id_t           owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, cpu_datao_q, con_datao_q;
    logic              cpu_ack_q, con_ack_q, we_n_q, oe_n_q, doe_q;
    logic              grant_s, grant_wr_s, fair_force_s;
    req_id_t           grant_id_s;

    // Arbitration in IDLE and fixed sequencing through the access phases.
    always_comb begin
        state_d    = state_q;
        grant_s    = 1'b0;
        grant_id_s = REQ_CPU;
        grant_wr_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpuREQ || conREQ) begin
                    grant_s    = 1'b1;
                    grant_id_s = (conREQ && (!cpuREQ || fair_force_s)) ? REQ_CON : REQ_CPU;
                    grant_wr_s = (grant_id_s == REQ_CON) ? conWR : cpuWR;
                    state_d    = grant_wr_s ? ST_WR_A : ST_RD_A;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_A: state_d = ST_WR_D;
            ST_WR_D: state_d = ST_IDLE;
            ST_RD_A: state_d = ST_RD_W;
            ST_RD_W: state_d = ST_RD_D;
            ST_RD_D: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes and ACKs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= REQ_CPU;
            addr_q      <= {ADDR_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            cpu_datao_q <= {DATA_W{1'b0}};
            con_datao_q <= {DATA_W{1'b0}};
            cpu_ack_q   <= 1'b0;
            con_ack_q   <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            doe_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_n_q    <= (state_d != ST_WR_A);
            oe_n_q    <= !((state_d == ST_RD_A) || (state_d == ST_RD_W));
            doe_q     <= (state_d == ST_WR_D);
            cpu_ack_q <= is_ack_state(state_d) && (owner_q == REQ_CPU);
            con_ack_q <= is_ack_state(state_d) && (owner_q == REQ_CON);
            if (grant_s) begin
                owner_q <= grant_id_s;
                addr_q  <= (grant_id_s == REQ_CON) ? conADDR : cpuADDR;
                wdata_q <= (grant_id_s == REQ_CON) ? conDATAI : cpuDATAI;
            end
            // SSRAM data is valid at the end of the wait cycle.
            if (state_q == ST_RD_W) begin
                if (owner_q == REQ_CON) begin
                    con_datao_q <= ssramDIN;
                end else begin
                    cpu_datao_q <= ssramDIN;
                end
            end
        end
    end

`ifdef MEM_ARB_FAIR_EN
    localparam int CNT_W = $clog2(FAIR_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FAIR_LIMIT);

    logic [CNT_W-1:0] fair_cnt_q, fair_cnt_d;

    // Counts CPU grants taken while the console is waiting.
    always_comb begin
        fair_cnt_d = fair_cnt_q;
        if (!conREQ || (grant_s && (grant_id_s == REQ_CON))) begin
            fair_cnt_d = {CNT_W{1'b0}};
        end else if (grant_s && (fair_cnt_q != LIMIT)) begin
            fair_cnt_d = fair_cnt_q + CNT_W'(1);
        end else begin
            fair_cnt_d = fair_cnt_q;
        end
    end

    // Fairness counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            fair_cnt_q <= {CNT_W{1'b0}};
        end else begin
            fair_cnt_q <= fair_cnt_d;
        end
    end

    assign fair_force_s = (fair_cnt_q == LIMIT);
`else
    assign fair_force_s = 1'b0;
`endif

    assign cpuACK    = cpu_ack_q;
    assign conACK    = con_ack_q;
    assign cpuDATAO  = cpu_datao_q;
    assign conDATAO  = con_datao_q;
    assign ssramADDR = {3'b000, addr_q};
    assign ssramWE_N = we_n_q;
    assign ssramOE_N = oe_n_q;
    assign ssramDOE  = doe_q;
    assign ssramDOUT = wdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: directed CPU/console transactions against a
// small synchronous SSRAM model; a negedge monitor checks every ACK.
module tb_mem_arb;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpuREQ, cpuWR, conREQ, conWR;
    logic [19:0] cpuADDR, conADDR;
    logic [35:0] cpuDATAI, conDATAI, cpuDATAO, conDATAO, ssramDOUT, ssramDIN;
    logic        cpuACK, conACK, ssramWE_N, ssramOE_N, ssramDOE;
    logic [22:0] ssramADDR;

    mem_arb #(.FAIR_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpuREQ(cpuREQ), .cpuWR(cpuWR), .cpuADDR(cpuADDR), .cpuDATAI(cpuDATAI),
        .cpuACK(cpuACK), .cpuDATAO(cpuDATAO),
        .conREQ(conREQ), .conWR(conWR), .conADDR(conADDR), .conDATAI(conDATAI),
        .conACK(conACK), .conDATAO(conDATAO),
        .ssramADDR(ssramADDR), .ssramWE_N(ssramWE_N), .ssramOE_N(ssramOE_N),
        .ssramDOUT(ssramDOUT), .ssramDOE(ssramDOE), .ssramDIN(ssramDIN)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous SSRAM model.
    logic [35:0] mem [0:4095];
    always @(posedge clk) begin
        if (!ssramOE_N) ssramDIN <= mem[ssramADDR[11:0]];
        if (ssramDOE) mem[ssramADDR[11:0]] <= ssramDOUT;
    end

    typedef struct packed {
        logic        who;
        logic        rd;
        logic [35:0] data;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    int   we_low_cnt = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0o expected %0o (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input logic who, input logic rd, input logic [35:0] d, input int c);
        exp_t e;
        e.who  = who;
        e.rd   = rd;
        e.data = d;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: strobe exclusivity every cycle, scoreboard pop on every ACK.
    always @(negedge clk) begin
        exp_t e;
        if (!ssramWE_N) we_low_cnt++;
        check("we_oe_excl", 64'(ssramWE_N | ssramOE_N), 64'd1);
        check("ack_excl", 64'(cpuACK & conACK), 64'd0);
        if (cpuACK || conACK) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("ack_who", 64'(conACK), 64'(e.who));
                check("ack_cycle", 64'(cyc), 64'(e.cyc));
                if (e.rd) check("rd_data", 64'(conACK ? conDATAO : cpuDATAO), 64'(e.data));
            end
        end
    end

    task automatic cpu_req(input logic wr, input logic [19:0] a, input logic [35:0] d);
        int n = 0;
        cpuWR = wr; cpuADDR = a; cpuDATAI = d; cpuREQ = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!cpuACK && n < 60);
        check("cpu_ack_seen", 64'(cpuACK), 64'd1);
        @(posedge clk);
        #1;
        cpuREQ = 1'b0;
    endtask

    task automatic con_req(input logic wr, input logic [19:0] a, input logic [35:0] d);
        int n = 0;
        conWR = wr; conADDR = a; conDATAI = d; conREQ = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!conACK && n < 60);
        check("con_ack_seen", 64'(conACK), 64'd1);
        @(posedge clk);
        #1;
        conREQ = 1'b0;
    endtask

    localparam logic [35:0] D_CPU = 36'o123456701234;
    localparam logic [35:0] D_CON = 36'o707070707070;

    initial begin
        int b;
        int w0;
        int con_pos;
`ifdef MEM_ARB_FAIR_EN
        con_pos = 4;
`else
        con_pos = 6;
`endif
        rst = 1'b1;
        cpuREQ = 1'b0; cpuWR = 1'b0; cpuADDR = 20'd0; cpuDATAI = 36'd0;
        conREQ = 1'b0; conWR = 1'b0; conADDR = 20'd0; conDATAI = 36'd0;
        repeat (3) tick();
        check("rst_cpuACK", 64'(cpuACK), 64'd0);
        check("rst_conACK", 64'(conACK), 64'd0);
        check("rst_we_n", 64'(ssramWE_N), 64'd1);
        check("rst_oe_n", 64'(ssramOE_N), 64'd1);
        check("rst_doe", 64'(ssramDOE), 64'd0);
        check("rst_cpuDATAO", 64'(cpuDATAO), 64'd0);
        check("rst_conDATAO", 64'(conDATAO), 64'd0);
        check("rst_addr", 64'(ssramADDR), 64'd0);
        rst = 1'b0;
        tick();

        // CPU write then read-back of the same word.
        w0 = we_low_cnt;
        b = cyc; push(REQ_CPU, 1'b0, 36'd0, b + 2); cpu_req(1'b1, 20'o1234, D_CPU);
        check("we_pulse_len", 64'(we_low_cnt - w0), 64'd1);
        b = cyc; push(REQ_CPU, 1'b1, D_CPU, b + 3); cpu_req(1'b0, 20'o1234, 36'd0);

        // Seed two more words, one through each port.
        b = cyc; push(REQ_CPU, 1'b0, 36'd0, b + 2); cpu_req(1'b1, 20'o100, 36'o55);
        b = cyc; push(REQ_CON, 1'b0, 36'd0, b + 2); con_req(1'b1, 20'o777, D_CON);

        // Console read must leave the CPU's read data untouched.
        b = cyc; push(REQ_CPU, 1'b1, 36'o55, b + 3); cpu_req(1'b0, 20'o100, 36'd0);
        b = cyc; push(REQ_CON, 1'b1, D_CON, b + 3); con_req(1'b0, 20'o777, 36'd0);
        check("cpuDATAO_hold", 64'(cpuDATAO), 64'o55);
        check("conDATAO_val", 64'(conDATAO), 64'(D_CON));

        // Simultaneous reads: CPU first, console ACK four cycles later.
        b = cyc;
        push(REQ_CPU, 1'b1, D_CPU, b + 3);
        push(REQ_CON, 1'b1, 36'o55, b + 7);
        fork
            cpu_req(1'b0, 20'o1234, 36'd0);
            con_req(1'b0, 20'o100, 36'd0);
        join

        // Back-to-back CPU reads with the console pending the whole time.
        b = cyc;
        for (int k = 0; k < 7; k++) begin
            if (k == con_pos) push(REQ_CON, 1'b1, D_CON, b + 3 + 4 * k);
            else              push(REQ_CPU, 1'b1, D_CPU, b + 3 + 4 * k);
        end
        fork
            begin
                for (int i = 0; i < 6; i++) cpu_req(1'b0, 20'o1234, 36'd0);
            end
            con_req(1'b0, 20'o777, 36'd0);
        join

        // Reset during RD_W aborts the read; the held request is served afterwards.
        b = cyc;
        push(REQ_CPU, 1'b1, D_CPU, b + 6);
        fork
            cpu_req(1'b0, 20'o1234, 36'd0);
            begin
                tick();
                tick();
                rst = 1'b1;
                tick();
                check("abort_oe_n", 64'(ssramOE_N), 64'd1);
                check("abort_we_n", 64'(ssramWE_N), 64'd1);
                check("abort_cpuACK", 64'(cpuACK), 64'd0);
                check("abort_cpuDATAO", 64'(cpuDATAO), 64'd0);
                check("abort_addr", 64'(ssramADDR), 64'd0);
                rst = 1'b0;
            end
        join

        repeat (3) tick();
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", compared, mismatched);
        $fatal(1, "watchdog expired");
    end

endmodule
